// File: rtl/sha256_w_sched.sv
// SHA-256 message schedule: loads one 512-bit block and streams W[0..ROUNDS-1],
// one word per enabled cycle, with init/done strobes for the round datapath.
module sha256_w_sched #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] msg_in,
  input  logic         en,
  output logic         ready,
  output logic [31:0]  w_out,
  output logic         w_valid,
  output logic [5:0]   round,
  output logic         init,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [5:0] ROUND_LAST = 6'(ROUNDS - 1);

  state_t      state_q;
  logic [5:0]  round_q;
  logic [31:0] w_q [16];
  logic [31:0] wNew_d;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // W[t+16] from the window w[k]=W[t+k]; carries out of bit 31 are discarded
  always_comb begin
    wNew_d = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      for (int k = 0; k < 16; k++) w_q[k] <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            round_q <= '0;
            for (int k = 0; k < 16; k++) w_q[k] <= msg_in[511 - 32*k -: 32];
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (en) begin
            if (round_q == ROUND_LAST) begin
              state_q <= DONE;
            end else begin
              for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
              w_q[15] <= wNew_d;
              round_q <= round_q + 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs follow the registered state, so they are stable through the low clock phase
  assign w_out   = w_q[0];
  assign round   = round_q;
  assign w_valid = (state_q == RUN);
  assign init    = (state_q == RUN) && (round_q == 6'd0);
  assign done    = (state_q == DONE);
  assign ready   = (state_q == IDLE) || (state_q == DONE);

endmodule

// File: tb/tb_sha256_w_sched.sv
// Directed bench for sha256_w_sched: reset, "abc" block, stalls, back-to-back,
// ignored start, and an all-ones block exercising modular overflow.
module tb_sha256_w_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] msg_in;
  logic         en;
  logic         ready;
  logic [31:0]  w_out;
  logic         w_valid;
  logic [5:0]   round;
  logic         init;
  logic         done;

  int nAsserts = 0;
  int nFail = 0;

  logic [31:0]  expW [64];
  logic [511:0] abcBlk;
  logic [511:0] onesBlk;

  sha256_w_sched #(.ROUNDS(64)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .msg_in(msg_in),
    .en(en),
    .ready(ready),
    .w_out(w_out),
    .w_valid(w_valid),
    .round(round),
    .init(init),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  // Reference schedule held as a flat array indexed by t
  task automatic buildModel(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int k = 0; k < 16; k++) expW[k] = blk[511 - 32*k -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(expW[t-15], 7) ^ rr(expW[t-15], 18) ^ (expW[t-15] >> 3);
      s1 = rr(expW[t-2], 17) ^ rr(expW[t-2], 19) ^ (expW[t-2] >> 10);
      expW[t] = s1 + expW[t-7] + s0 + expW[t-16];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walks the schedule from round 0 to the DONE cycle, optionally stalling or poking start
  task automatic runSchedule(input int blkId, input int stallA, input int stallB,
                             input int ignoreAt, input logic [511:0] altBlk);
    for (int t = 0; t < 64; t++) begin
      checkVal($sformatf("w_out t=%0d", t), w_out, expW[t]);
      checkVal($sformatf("round t=%0d", t), {26'b0, round}, 32'(t));
      checkVal($sformatf("init t=%0d", t), {31'b0, init}, (t == 0) ? 32'd1 : 32'd0);
      checkVal($sformatf("w_valid t=%0d", t), {31'b0, w_valid}, 32'd1);
      checkVal($sformatf("done t=%0d", t), {31'b0, done}, 32'd0);
      if (t == 5) checkVal("ready in RUN", {31'b0, ready}, 32'd0);
      if (blkId == 1 && t == 0)  checkVal("abc W0", w_out, 32'h61626380);
      if (blkId == 1 && t == 15) checkVal("abc W15", w_out, 32'h00000018);
      if (blkId == 1 && t == 16) checkVal("abc W16", w_out, 32'h61626380);
      if (blkId == 1 && t == 17) checkVal("abc W17", w_out, 32'h000F0000);
      if (blkId == 2 && t == 0)  checkVal("ones W0", w_out, 32'hFFFFFFFF);
      if (blkId == 2 && t == 16) checkVal("ones W16", w_out, 32'h203FFFFC);
      if (t == stallA || t == stallB) begin
        en = 1'b0;
        repeat (3) begin
          step();
          checkVal($sformatf("stall round t=%0d", t), {26'b0, round}, 32'(t));
          checkVal($sformatf("stall w_out t=%0d", t), w_out, expW[t]);
          checkVal($sformatf("stall init t=%0d", t), {31'b0, init}, (t == 0) ? 32'd1 : 32'd0);
          checkVal($sformatf("stall done t=%0d", t), {31'b0, done}, 32'd0);
        end
        en = 1'b1;
      end
      if (t == ignoreAt) begin
        start = 1'b1;
        msg_in = altBlk;
        step();
        start = 1'b0;
      end else begin
        step();
      end
    end
    checkVal("done pulse", {31'b0, done}, 32'd1);
    checkVal("w_valid in DONE", {31'b0, w_valid}, 32'd0);
    checkVal("ready in DONE", {31'b0, ready}, 32'd1);
    checkVal("init in DONE", {31'b0, init}, 32'd0);
    checkVal("w_out held W63", w_out, expW[63]);
  endtask

  initial begin
    abcBlk = '0;
    abcBlk[511:480] = 32'h61626380;
    abcBlk[31:0] = 32'h00000018;
    onesBlk = '1;
    rst = 1'b1;
    start = 1'b0;
    en = 1'b1;
    msg_in = '0;
    step();
    step();
    rst = 1'b0;
    checkVal("reset ready", {31'b0, ready}, 32'd1);
    checkVal("reset w_valid", {31'b0, w_valid}, 32'd0);
    checkVal("reset round", {26'b0, round}, 32'd0);
    checkVal("reset init", {31'b0, init}, 32'd0);
    checkVal("reset done", {31'b0, done}, 32'd0);
    checkVal("reset w_out", w_out, 32'd0);

    $display("[TB] reset during RUN");
    buildModel(abcBlk);
    msg_in = abcBlk;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    checkVal("pre-reset round", {26'b0, round}, 32'd20);
    checkVal("pre-reset w_out", w_out, expW[20]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkVal("midrst w_valid", {31'b0, w_valid}, 32'd0);
    checkVal("midrst round", {26'b0, round}, 32'd0);
    checkVal("midrst ready", {31'b0, ready}, 32'd1);
    checkVal("midrst done", {31'b0, done}, 32'd0);
    checkVal("midrst w_out", w_out, 32'd0);

    $display("[TB] abc block after restart");
    start = 1'b1;
    step();
    start = 1'b0;
    runSchedule(1, -1, -1, -1, abcBlk);
    step();
    checkVal("done one cycle", {31'b0, done}, 32'd0);
    checkVal("idle ready", {31'b0, ready}, 32'd1);
    checkVal("idle w_valid", {31'b0, w_valid}, 32'd0);
    checkVal("idle w_out held", w_out, expW[63]);

    $display("[TB] stalls at round 0 and 30");
    start = 1'b1;
    step();
    start = 1'b0;
    runSchedule(1, 0, 30, -1, abcBlk);

    $display("[TB] back-to-back all-ones block with ignored start");
    start = 1'b1;
    msg_in = onesBlk;
    step();
    start = 1'b0;
    buildModel(onesBlk);
    runSchedule(2, -1, -1, 10, abcBlk);
    step();
    checkVal("final done low", {31'b0, done}, 32'd0);
    checkVal("final ready", {31'b0, ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
